// File: rtl/ysyx_040750_mdu_pkg.sv
// Shared definitions for the EX-stage iterative multiply/divide unit.
// Op codes follow RV64M funct3.
package ysyx_040750_mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

  localparam logic [6:0] MDU_CNT_D = 7'd64;
  localparam logic [6:0] MDU_CNT_W = 7'd32;

  function automatic logic [63:0] sext_w(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/ysyx_040750_div_step.sv
// One restoring-divide step: trial-subtract the divisor from the
// shifted partial remainder and keep the difference if non-negative.
module ysyx_040750_div_step (
  input  logic [64:0] rem,
  input  logic [63:0] dvsr,
  output logic [63:0] rem_nxt,
  output logic        q_bit
);

  logic [65:0] diff;

  always_comb begin
    diff    = {1'b0, rem} - {2'b0, dvsr};
    q_bit   = ~diff[65];
    rem_nxt = q_bit ? diff[63:0] : rem[63:0];
  end

endmodule

// File: rtl/ysyx_040750_ex_muldiv.sv
// EX-stage RV64M multiply/divide: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, sign fixed up at the end.
module ysyx_040750_ex_muldiv
  import ysyx_040750_mdu_pkg::*;
(
  input  logic        I_sys_clk,
  input  logic        I_rst,
  input  logic        I_start,
  input  logic        I_flush,
  input  logic [2:0]  I_op,
  input  logic        I_word,
  input  logic [63:0] I_src1,
  input  logic [63:0] I_src2,
  input  logic        I_out_ready,
  output logic        O_idle,
  output logic        O_valid,
  output logic [63:0] O_result
);

  mdu_state_e state_q, state_d;

  logic [2:0]   op_q;
  logic         word_q;
  logic         neg_q;
  logic         sgn1_q;
  logic [6:0]   cnt_q;
  logic [127:0] acc_q;
  logic [127:0] mcand_q;
  logic [63:0]  mplier_q;
  logic [63:0]  rem_q;
  logic [63:0]  quo_q;
  logic [63:0]  dvsr_q;
  logic [63:0]  res_q;

  logic         s1_sgn, s2_sgn;
  logic [63:0]  a_ext, b_ext;
  logic         a_neg, b_neg;
  logic [63:0]  a_mag, b_mag;
  logic [63:0]  op_min;
  logic         dz, ovf;
  logic [63:0]  spec_res, spec_res_w;

  always_comb begin
    s1_sgn = (I_op != MDU_MULHU) && (I_op != MDU_DIVU)
          && (I_op != MDU_REMU);
    s2_sgn = s1_sgn && (I_op != MDU_MULHSU);
    a_ext  = I_src1;
    b_ext  = I_src2;
    if (I_word) begin
      a_ext = s1_sgn ? sext_w(I_src1[31:0]) : {32'b0, I_src1[31:0]};
      b_ext = s2_sgn ? sext_w(I_src2[31:0]) : {32'b0, I_src2[31:0]};
    end
    a_neg  = s1_sgn & a_ext[63];
    b_neg  = s2_sgn & b_ext[63];
    a_mag  = a_neg ? -a_ext : a_ext;
    b_mag  = b_neg ? -b_ext : b_ext;
    op_min = I_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    dz     = I_op[2] && (b_ext == 64'd0);
    ovf    = I_op[2] && !I_op[0] && (a_ext == op_min) && (&b_ext);
    // Special cases resolve in IDLE and bypass the iteration entirely
    if (dz) spec_res = I_op[1] ? a_ext : '1;
    else    spec_res = I_op[1] ? '0 : a_ext;
    spec_res_w = I_word ? sext_w(spec_res[31:0]) : spec_res;
  end

  logic [63:0] rem_nxt;
  logic        q_bit;

  ysyx_040750_div_step u_div_step (
    .rem     ({rem_q, quo_q[63]}),
    .dvsr    (dvsr_q),
    .rem_nxt (rem_nxt),
    .q_bit   (q_bit)
  );

  logic [127:0] prod;
  logic [63:0]  quo_f, rem_f, res64, fix_res;

  always_comb begin
    prod  = neg_q ? -acc_q : acc_q;
    quo_f = neg_q ? -quo_q : quo_q;
    rem_f = sgn1_q ? -rem_q : rem_q;
    unique case (op_q)
      MDU_MUL:                      res64 = prod[63:0];
      MDU_MULH, MDU_MULHSU,
      MDU_MULHU:                    res64 = prod[127:64];
      MDU_DIV, MDU_DIVU:            res64 = quo_f;
      default:                      res64 = rem_f;
    endcase
    fix_res = word_q ? sext_w(res64[31:0]) : res64;
  end

  always_ff @(posedge I_sys_clk) begin
    if (I_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (I_flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (I_start) state_d = (dz || ovf) ? DONE : CALC;
        CALC: if (cnt_q == 7'd1) state_d = FIX;
        FIX:  state_d = DONE;
        DONE: if (I_out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      op_q     <= '0;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      sgn1_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      res_q    <= '0;
    end else if (!I_flush) begin
      unique case (state_q)
        IDLE: if (I_start) begin
          op_q     <= I_op;
          word_q   <= I_word;
          neg_q    <= a_neg ^ b_neg;
          sgn1_q   <= a_neg;
          cnt_q    <= I_word ? MDU_CNT_W : MDU_CNT_D;
          acc_q    <= '0;
          mcand_q  <= {64'b0, a_mag};
          mplier_q <= b_mag;
          rem_q    <= '0;
          // W dividend sits in the top half so 32 shifts consume it
          quo_q    <= I_word ? {a_mag[31:0], 32'b0} : a_mag;
          dvsr_q   <= b_mag;
          if (dz || ovf) res_q <= spec_res_w;
        end
        CALC: begin
          cnt_q <= cnt_q - 7'd1;
          if (op_q[2]) begin
            rem_q <= rem_nxt;
            quo_q <= {quo_q[62:0], q_bit};
          end else begin
            if (mplier_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
          end
        end
        FIX: res_q <= fix_res;
        default: ;
      endcase
    end
  end

  assign O_idle   = (state_q == IDLE);
  assign O_valid  = (state_q == DONE);
  assign O_result = res_q;

endmodule
